ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register for the 16-bit WISC pipeline; consumes the ID/EX register outputs (ex_* signals).
- Computes the ALU result, memory address or load-half result.
- Holds the architectural Z/V/N flag register.
- Registers everything the MEM and WB stages need on mem_* outputs.

Parameters:
- HALT_OPCODE, 4'hF, opcode that raises mem_halt.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall_n  in  1  0 = hold all state.
- flush  in  1  1 = load bubble into EX/MEM.
- ex_rs_data  in  16  first operand.
- ex_rt_data  in  16  second operand / store data.
- ex_imm  in  16  immediate; already sign-extended, and already shifted for LW/SW.
- ex_opcode  in  4  instruction opcode.
- ex_imm_instr  in  1  use ex_imm as second ALU operand.
- ex_load_half_instr  in  1  LLB/LHB.
- ex_load_half_data  in  16  old rd value for LLB/LHB.
- ex_mem_write  in  1  store.
- ex_WriteReg  in  1  register write enable.
- mem_alu_result  out  16  registered result or address.
- mem_rt_data  out  16  registered store data.
- mem_mem_write  out  1  registered store enable.
- mem_mem_read  out  1  registered; 1 for LW.
- mem_WriteReg  out  1  registered write enable.
- mem_halt  out  1  registered halt.
- flag_z, flag_v, flag_n  out  1 each  flag register, directly from flops.

Behaviour:
- Reset: every mem_* output is 0 and every flag is 0, asynchronously. Release takes effect on the next posedge.
- Latency: one cycle from ex_* inputs to mem_* outputs and flags.
- Operand B = ex_imm_instr ? ex_imm : ex_rt_data.
- ADD (0000) / SUB (0001): 16-bit signed, saturating.
  - Positive overflow gives 0x7FFF; negative overflow gives 0x8000.
  - Sets Z (result==0), N (result[15]) and V (overflow occurred).
- XOR (0010): A ^ B. Sets Z only.
- RED (0011): sum of signed bytes rs[15:8], rs[7:0], rt[15:8], rt[7:0]. The 10-bit sum is sign-extended to 16. Flags unchanged.
- SLL (0100) / SRA (0101) / ROR (0110): shift or rotate rs by ex_imm[3:0]. Sets Z only.
- PADDSB (0111): four independent 4-bit signed lanes, each saturating to the range 0x7..0x8. Flags unchanged.
- LW (1000) / SW (1001): result = (rs & 0xFFFE) + ex_imm, wrap-around, no saturation. mem_mem_read = 1 for LW.
- LLB (1010): result = {ex_load_half_data[15:8], ex_imm[7:0]}.
- LHB (1011): result = {ex_imm[7:0], ex_load_half_data[7:0]}.
- B (1100), BR (1101), PCS (1110): result = 0. Flags unchanged. PC logic is outside this block.
- HALT_OPCODE: mem_halt = 1. Result 0, flags unchanged.
- Flags not written by an opcode keep their prior value.
- Control outputs pass through with one cycle delay: mem_mem_write = ex_mem_write, mem_WriteReg = ex_WriteReg.
- Priority on each posedge:
  - flush=1: load bubble (all mem_* = 0); flags unchanged. Flush wins over stall.
  - else stall_n=0: all mem_* and flags hold.
  - else: load computed values and update flags per opcode.
- Reset asserted mid-operation clears state immediately. No partial update is permitted on the edge where rst rises.

Test Plan:
- ADD rs=0x7FFF, rt=0x0001 -> mem_alu_result=0x7FFF, V=1, N=0, Z=0. Then SUB 0x0005-0x0005 -> 0x0000, Z=1, V=0, N=0.
- PADDSB rs=0x7777, rt=0x1111 -> 0x7777. Then XOR 0x00FF^0x00FF -> 0x0000, Z=1, with V/N retained from the prior SUB.
- RED rs=0x7F7F, rt=0x7F7F -> 0x01FC. Then SRA rs=0x8000, imm=0x000F -> 0xFFFF, Z=0.
- LW rs=0x1003, imm=0x0004 -> result=0x1006, mem_mem_read=1. SW same operands with rt=0xBEEF -> mem_rt_data=0xBEEF, mem_mem_write=1.
- LHB imm=0x00AB, load_half_data=0x1234 -> 0xAB34. Then LLB imm=0x00CD -> 0x12CD.
- Stall and flush ordering:
  - stall_n=0 for 3 cycles with changing inputs -> outputs and flags frozen.
  - flush=1 with stall_n=0 and ADD overflow inputs -> all mem_* = 0, flags unchanged.
  - rst pulse between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Execute stage and EX/MEM pipeline register for the 16-bit WISC pipeline.
//   Takes the ID/EX register outputs (ex_*), computes the ALU result, memory
//   address or load-half value, and registers everything MEM/WB need onto the
//   mem_* outputs one cycle later. Also holds the architectural Z/V/N flags.
//
// Ports
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   stall_n              0 = hold EX/MEM register and flags
//   flush                1 = load a bubble into EX/MEM (wins over stall), flags hold
//   ex_rs_data           first operand
//   ex_rt_data           second operand / store data
//   ex_imm               sign-extended immediate (pre-shifted for LW/SW)
//   ex_opcode            instruction opcode
//   ex_imm_instr         select ex_imm as second ALU operand
//   ex_load_half_instr   LLB/LHB marker from decode
//   ex_load_half_data    old rd value for LLB/LHB
//   ex_mem_write         store enable
//   ex_WriteReg          register write enable
//   mem_alu_result       registered result / address
//   mem_rt_data          registered store data
//   mem_mem_write        registered store enable
//   mem_mem_read         registered load enable (LW)
//   mem_WriteReg         registered register write enable
//   mem_halt             registered halt
//   flag_z/flag_v/flag_n flag register
module ex_mem_stage #(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_n,
  input  logic        flush,
  input  logic [15:0] ex_rs_data,
  input  logic [15:0] ex_rt_data,
  input  logic [15:0] ex_imm,
  input  logic [3:0]  ex_opcode,
  input  logic        ex_imm_instr,
  input  logic        ex_load_half_instr,
  input  logic [15:0] ex_load_half_data,
  input  logic        ex_mem_write,
  input  logic        ex_WriteReg,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_rt_data,
  output logic        mem_mem_write,
  output logic        mem_mem_read,
  output logic        mem_WriteReg,
  output logic        mem_halt,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;

  // The opcode alone identifies LLB/LHB; the decode marker is redundant here.
  logic unused_load_half;
  assign unused_load_half = ex_load_half_instr;

  logic [15:0] opnd_b;
  assign opnd_b = ex_imm_instr ? ex_imm : ex_rt_data;

  // Saturating add/sub: 17-bit sign-extended result; bits 16 and 15 disagree
  // exactly when the 16-bit signed result overflowed, and bit 16 is the true sign.
  logic [16:0] add_full;
  logic [16:0] sub_full;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] add_sat;
  logic [15:0] sub_sat;

  assign add_full = {ex_rs_data[15], ex_rs_data} + {opnd_b[15], opnd_b};
  assign sub_full = {ex_rs_data[15], ex_rs_data} - {opnd_b[15], opnd_b};
  assign add_ovf  = add_full[16] ^ add_full[15];
  assign sub_ovf  = sub_full[16] ^ sub_full[15];
  assign add_sat  = add_ovf ? (add_full[16] ? 16'h8000 : 16'h7FFF) : add_full[15:0];
  assign sub_sat  = sub_ovf ? (sub_full[16] ? 16'h8000 : 16'h7FFF) : sub_full[15:0];

  // Reduction: four signed bytes always fit in 10 bits, so no overflow.
  logic [9:0]  red_sum;
  logic [15:0] red_res;
  assign red_sum = {{2{ex_rs_data[15]}}, ex_rs_data[15:8]}
                 + {{2{ex_rs_data[7]}},  ex_rs_data[7:0]}
                 + {{2{ex_rt_data[15]}}, ex_rt_data[15:8]}
                 + {{2{ex_rt_data[7]}},  ex_rt_data[7:0]};
  assign red_res = {{6{red_sum[9]}}, red_sum};

  logic [15:0] sll_res;
  logic [15:0] sra_res;
  logic [31:0] ror_full;
  logic [15:0] ror_res;
  assign sll_res  = ex_rs_data << ex_imm[3:0];
  assign sra_res  = $signed(ex_rs_data) >>> ex_imm[3:0];
  assign ror_full = {ex_rs_data, ex_rs_data} >> ex_imm[3:0];
  assign ror_res  = ror_full[15:0];

  logic [15:0] paddsb_res;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [4:0] lane_sum;
    assign lane_sum = {ex_rs_data[4*i+3], ex_rs_data[4*i +: 4]}
                    + {opnd_b[4*i+3], opnd_b[4*i +: 4]};
    assign paddsb_res[4*i +: 4] = (lane_sum[4] ^ lane_sum[3])
                                ? (lane_sum[4] ? 4'h8 : 4'h7)
                                : lane_sum[3:0];
  end

  logic [15:0] addr_res;
  assign addr_res = (ex_rs_data & 16'hFFFE) + ex_imm;

  logic        is_halt;
  logic [15:0] alu_res;
  logic        z_we;
  logic        vn_we;
  logic        v_nxt;
  logic        z_nxt;
  logic        n_nxt;
  logic        mem_rd_nxt;

  assign is_halt = (ex_opcode == HALT_OPCODE);

  always_comb begin
    alu_res    = '0;
    z_we       = 1'b0;
    vn_we      = 1'b0;
    v_nxt      = 1'b0;
    mem_rd_nxt = 1'b0;
    if (!is_halt) begin
      case (ex_opcode)
        OP_ADD: begin
          alu_res = add_sat;
          v_nxt   = add_ovf;
          z_we    = 1'b1;
          vn_we   = 1'b1;
        end
        OP_SUB: begin
          alu_res = sub_sat;
          v_nxt   = sub_ovf;
          z_we    = 1'b1;
          vn_we   = 1'b1;
        end
        OP_XOR: begin
          alu_res = ex_rs_data ^ opnd_b;
          z_we    = 1'b1;
        end
        OP_RED:    alu_res = red_res;
        OP_SLL: begin
          alu_res = sll_res;
          z_we    = 1'b1;
        end
        OP_SRA: begin
          alu_res = sra_res;
          z_we    = 1'b1;
        end
        OP_ROR: begin
          alu_res = ror_res;
          z_we    = 1'b1;
        end
        OP_PADDSB: alu_res = paddsb_res;
        OP_LW: begin
          alu_res    = addr_res;
          mem_rd_nxt = 1'b1;
        end
        OP_SW:     alu_res = addr_res;
        OP_LLB:    alu_res = {ex_load_half_data[15:8], ex_imm[7:0]};
        OP_LHB:    alu_res = {ex_imm[7:0], ex_load_half_data[7:0]};
        default:   alu_res = '0;
      endcase
    end
    z_nxt = (alu_res == 16'h0000);
    n_nxt = alu_res[15];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_alu_result <= '0;
      mem_rt_data    <= '0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_WriteReg   <= 1'b0;
      mem_halt       <= 1'b0;
      flag_z         <= 1'b0;
      flag_v         <= 1'b0;
      flag_n         <= 1'b0;
    end else if (flush) begin
      mem_alu_result <= '0;
      mem_rt_data    <= '0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_WriteReg   <= 1'b0;
      mem_halt       <= 1'b0;
    end else if (stall_n) begin
      mem_alu_result <= alu_res;
      mem_rt_data    <= ex_rt_data;
      mem_mem_write  <= ex_mem_write;
      mem_mem_read   <= mem_rd_nxt;
      mem_WriteReg   <= ex_WriteReg;
      mem_halt       <= is_halt;
      if (z_we) begin
        flag_z <= z_nxt;
      end
      if (vn_we) begin
        flag_v <= v_nxt;
        flag_n <= n_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_n = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] ex_rs_data = '0;
  logic [15:0] ex_rt_data = '0;
  logic [15:0] ex_imm = '0;
  logic [3:0]  ex_opcode = '0;
  logic        ex_imm_instr = 1'b0;
  logic        ex_load_half_instr = 1'b0;
  logic [15:0] ex_load_half_data = '0;
  logic        ex_mem_write = 1'b0;
  logic        ex_WriteReg = 1'b0;
  logic [15:0] mem_alu_result;
  logic [15:0] mem_rt_data;
  logic        mem_mem_write;
  logic        mem_mem_read;
  logic        mem_WriteReg;
  logic        mem_halt;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int errors = 0;
  int checks = 0;

  ex_mem_stage #(.HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall_n(stall_n), .flush(flush),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_opcode(ex_opcode), .ex_imm_instr(ex_imm_instr),
    .ex_load_half_instr(ex_load_half_instr), .ex_load_half_data(ex_load_half_data),
    .ex_mem_write(ex_mem_write), .ex_WriteReg(ex_WriteReg),
    .mem_alu_result(mem_alu_result), .mem_rt_data(mem_rt_data),
    .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .mem_WriteReg(mem_WriteReg), .mem_halt(mem_halt),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  typedef struct packed {
    logic [15:0] res;
    logic        wz;
    logic        wvn;
    logic        z;
    logic        v;
    logic        n;
    logic        halt;
    logic        rd;
  } ref_t;

  function automatic int sx(input logic [15:0] x, input int bits);
    int u;
    u = int'(x) & ((1 << bits) - 1);
    if (u >= (1 << (bits - 1))) u = u - (1 << bits);
    return u;
  endfunction

  function automatic ref_t compute(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] rt, input logic [15:0] imm,
                                   input logic immi, input logic [15:0] lhd);
    ref_t r;
    logic [15:0] b;
    int s;
    int sh;
    int u;
    r  = '0;
    b  = immi ? imm : rt;
    sh = int'(imm[3:0]);
    if (op == 4'hF) begin
      r.halt = 1'b1;
      return r;
    end
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sx(a, 16) + sx(b, 16) : sx(a, 16) - sx(b, 16);
        if (s > 32767) begin
          r.res = 16'h7FFF; r.v = 1'b1;
        end else if (s < -32768) begin
          r.res = 16'h8000; r.v = 1'b1;
        end else begin
          r.res = s[15:0];
        end
        r.wz = 1'b1; r.wvn = 1'b1;
      end
      4'h2: begin r.res = a ^ b; r.wz = 1'b1; end
      4'h3: begin
        s = sx({8'h0, a[15:8]}, 8) + sx({8'h0, a[7:0]}, 8)
          + sx({8'h0, rt[15:8]}, 8) + sx({8'h0, rt[7:0]}, 8);
        r.res = s[15:0];
      end
      4'h4: begin
        u = int'(a);
        for (int k = 0; k < sh; k++) u = u * 2;
        r.res = u[15:0]; r.wz = 1'b1;
      end
      4'h5: begin
        s = sx(a, 16);
        for (int k = 0; k < sh; k++) s = s >>> 1;
        r.res = s[15:0]; r.wz = 1'b1;
      end
      4'h6: begin
        u = int'(a);
        u = (u >> sh) | (u << (16 - sh));
        r.res = u[15:0]; r.wz = 1'b1;
      end
      4'h7: begin
        for (int l = 0; l < 4; l++) begin
          s = sx(a >> (4 * l), 4) + sx(b >> (4 * l), 4);
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r.res[4*l +: 4] = s[3:0];
        end
      end
      4'h8: begin r.res = (a & 16'hFFFE) + imm; r.rd = 1'b1; end
      4'h9: r.res = (a & 16'hFFFE) + imm;
      4'hA: r.res = {lhd[15:8], imm[7:0]};
      4'hB: r.res = {imm[7:0], lhd[7:0]};
      default: r.res = 16'h0000;
    endcase
    r.z = (r.res == 16'h0000);
    r.n = r.res[15];
    return r;
  endfunction

  logic [15:0] e_res = '0;
  logic [15:0] e_rt = '0;
  logic        e_mw = 1'b0;
  logic        e_rd = 1'b0;
  logic        e_wr = 1'b0;
  logic        e_halt = 1'b0;
  logic        e_z = 1'b0;
  logic        e_v = 1'b0;
  logic        e_n = 1'b0;
  ref_t        mr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_res = '0; e_rt = '0; e_mw = 0; e_rd = 0; e_wr = 0; e_halt = 0;
      e_z = 0; e_v = 0; e_n = 0;
    end else if (flush) begin
      e_res = '0; e_rt = '0; e_mw = 0; e_rd = 0; e_wr = 0; e_halt = 0;
    end else if (stall_n) begin
      mr     = compute(ex_opcode, ex_rs_data, ex_rt_data, ex_imm, ex_imm_instr, ex_load_half_data);
      e_res  = mr.res;
      e_rt   = ex_rt_data;
      e_mw   = ex_mem_write;
      e_wr   = ex_WriteReg;
      e_rd   = mr.rd;
      e_halt = mr.halt;
      if (mr.wz) e_z = mr.z;
      if (mr.wvn) begin
        e_v = mr.v;
        e_n = mr.n;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc result", mem_alu_result, e_res);
    check("cyc rt_data", mem_rt_data, e_rt);
    check("cyc mem_write", mem_mem_write, e_mw);
    check("cyc mem_read", mem_mem_read, e_rd);
    check("cyc WriteReg", mem_WriteReg, e_wr);
    check("cyc halt", mem_halt, e_halt);
    check("cyc flag_z", flag_z, e_z);
    check("cyc flag_v", flag_v, e_v);
    check("cyc flag_n", flag_n, e_n);
  end

  // ---------------- directed stimulus ----------------
  task automatic go(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                    input logic [15:0] imm, input logic immi, input logic lh,
                    input logic [15:0] lhd, input logic mw, input logic wr,
                    input logic stn, input logic fl);
    @(negedge clk);
    ex_opcode = op; ex_rs_data = rs; ex_rt_data = rt; ex_imm = imm;
    ex_imm_instr = immi; ex_load_half_instr = lh; ex_load_half_data = lhd;
    ex_mem_write = mw; ex_WriteReg = wr; stall_n = stn; flush = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic flags(input string name, input logic z, input logic v, input logic n);
    check({name, " Z"}, flag_z, z);
    check({name, " V"}, flag_v, v);
    check({name, " N"}, flag_n, n);
  endtask

  initial begin
    @(posedge clk);
    #2;
    check("reset result", mem_alu_result, 16'h0000);
    check("reset halt", mem_halt, 1'b0);
    flags("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    go(4'h0, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("add pos sat", mem_alu_result, 16'h7FFF);
    check("add WriteReg", mem_WriteReg, 1'b1);
    flags("add pos sat", 0, 1, 0);
    go(4'h1, 16'h0005, 16'h0005, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("sub zero", mem_alu_result, 16'h0000);
    flags("sub zero", 1, 0, 0);
    go(4'h7, 16'h7777, 16'h1111, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("paddsb sat", mem_alu_result, 16'h7777);
    go(4'h2, 16'h00FF, 16'h00FF, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("xor", mem_alu_result, 16'h0000);
    flags("xor", 1, 0, 0);
    go(4'h3, 16'h7F7F, 16'h7F7F, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("red pos", mem_alu_result, 16'h01FC);
    go(4'h5, 16'h8000, 16'h0000, 16'h000F, 0, 0, 16'h0, 0, 1, 1, 0);
    check("sra", mem_alu_result, 16'hFFFF);
    check("sra Z", flag_z, 1'b0);
    go(4'h8, 16'h1003, 16'h0000, 16'h0004, 1, 0, 16'h0, 0, 1, 1, 0);
    check("lw addr", mem_alu_result, 16'h1006);
    check("lw mem_read", mem_mem_read, 1'b1);
    go(4'h9, 16'h1003, 16'hBEEF, 16'h0004, 1, 0, 16'h0, 1, 0, 1, 0);
    check("sw addr", mem_alu_result, 16'h1006);
    check("sw rt_data", mem_rt_data, 16'hBEEF);
    check("sw mem_write", mem_mem_write, 1'b1);
    check("sw mem_read", mem_mem_read, 1'b0);
    go(4'hB, 16'h0000, 16'h0000, 16'h00AB, 0, 1, 16'h1234, 0, 1, 1, 0);
    check("lhb", mem_alu_result, 16'hAB34);
    go(4'hA, 16'h0000, 16'h0000, 16'h00CD, 0, 1, 16'h1234, 0, 1, 1, 0);
    check("llb", mem_alu_result, 16'h12CD);

    go(4'h0, 16'h8000, 16'hFFFF, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("add neg sat", mem_alu_result, 16'h8000);
    flags("add neg sat", 0, 1, 1);
    go(4'h1, 16'h7FFF, 16'hFFFF, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("sub pos sat", mem_alu_result, 16'h7FFF);
    flags("sub pos sat", 0, 1, 0);
    go(4'h0, 16'h0010, 16'h1111, 16'hFFF0, 1, 0, 16'h0, 0, 1, 1, 0);
    check("add imm", mem_alu_result, 16'h0000);
    flags("add imm", 1, 0, 0);
    go(4'h6, 16'h1234, 16'h0000, 16'h0004, 0, 0, 16'h0, 0, 1, 1, 0);
    check("ror", mem_alu_result, 16'h4123);
    go(4'h4, 16'h0001, 16'h0000, 16'h000F, 0, 0, 16'h0, 0, 1, 1, 0);
    check("sll", mem_alu_result, 16'h8000);
    go(4'h7, 16'h8888, 16'h8888, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("paddsb neg sat", mem_alu_result, 16'h8888);
    go(4'h7, 16'h1234, 16'h4321, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("paddsb plain", mem_alu_result, 16'h5555);
    go(4'h3, 16'h8080, 16'h8080, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("red neg", mem_alu_result, 16'hFE00);
    go(4'hC, 16'h1234, 16'h5678, 16'h0000, 0, 0, 16'h0, 0, 0, 1, 0);
    check("branch zero", mem_alu_result, 16'h0000);
    go(4'hF, 16'h1234, 16'h5678, 16'h0000, 0, 0, 16'h0, 0, 0, 1, 0);
    check("halt", mem_halt, 1'b1);
    check("halt result", mem_alu_result, 16'h0000);

    go(4'h0, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    go(4'h1, 16'h0005, 16'h0005, 16'h0000, 0, 0, 16'h0, 1, 0, 0, 0);
    check("stall1 result", mem_alu_result, 16'h7FFF);
    flags("stall1", 0, 1, 0);
    go(4'h2, 16'h00FF, 16'h00FF, 16'h0000, 0, 0, 16'h0, 1, 0, 0, 0);
    check("stall2 result", mem_alu_result, 16'h7FFF);
    check("stall2 mem_write", mem_mem_write, 1'b0);
    go(4'hF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0, 0, 0, 0, 0);
    check("stall3 halt", mem_halt, 1'b0);
    flags("stall3", 0, 1, 0);
    go(4'h0, 16'h8000, 16'hFFFF, 16'h0000, 0, 0, 16'h0, 1, 1, 0, 1);
    check("flush result", mem_alu_result, 16'h0000);
    check("flush WriteReg", mem_WriteReg, 1'b0);
    check("flush mem_write", mem_mem_write, 1'b0);
    flags("flush", 0, 1, 0);

    go(4'h8, 16'h1003, 16'h0000, 16'h0004, 1, 0, 16'h0, 0, 1, 1, 0);
    check("pre-rst addr", mem_alu_result, 16'h1006);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async rst result", mem_alu_result, 16'h0000);
    check("async rst mem_read", mem_mem_read, 1'b0);
    check("async rst WriteReg", mem_WriteReg, 1'b0);
    flags("async rst", 0, 0, 0);
    #1 rst = 1'b0;
    go(4'h1, 16'h8000, 16'h0001, 16'h0000, 0, 0, 16'h0, 0, 1, 1, 0);
    check("post-rst sub neg sat", mem_alu_result, 16'h8000);
    flags("post-rst", 0, 1, 1);

    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
